rms_calc: RTL and testbench
===========================

RMS_CALC -- requirements
Module: rms_calc

Interface
REQ-001 SHALL have parameter SUM_W, default 48, meaning width of the accumulated sum of squares.
REQ-002 SHALL have parameter CNT_W, default 14, meaning width of the sample count per window.
REQ-003 SHALL have parameter OUT_W, default 16, meaning width of the RMS result.
REQ-004 SHALL have port CLK_50M  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  one-cycle request to process one window.
REQ-007 SHALL have port sum_in  input  SUM_W  sum of squared offset-removed ADC codes for one window.
REQ-008 SHALL have port cnt_in  input  CNT_W  number of samples in that window.
REQ-009 SHALL have port busy  output  1  high while a calculation is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse when results are updated.
REQ-011 SHALL have port mean_sq  output  2*OUT_W  floor(sum/cnt), saturated.
REQ-012 SHALL have port rms_out  output  OUT_W  floor(sqrt(mean_sq)).
REQ-013 SHALL have port err_zero  output  1  last request had cnt_in==0.
REQ-014 SHALL have port sat  output  1  last quotient exceeded 2*OUT_W bits.

Function
REQ-015 SHALL implement states IDLE, DIV, SQRT, DONE; IDLE->DIV on start; DIV->SQRT after SUM_W iterations; SQRT->DONE after OUT_W iterations; DONE->IDLE unconditionally.
REQ-016 SHALL sample start only in IDLE and latch sum_in/cnt_in on that edge; start in any other state SHALL be ignored with no queuing.
REQ-017 SHALL assert busy in DIV, SQRT and DONE, and deassert it in IDLE.
REQ-018 SHALL divide with a restoring algorithm, one quotient bit per cycle, MSB first, unsigned, producing a SUM_W-bit quotient.
REQ-019 SHALL clamp the quotient to 2^(2*OUT_W)-1 and set sat=1 if any bit above bit 2*OUT_W-1 is set; otherwise sat=0.
REQ-020 SHALL compute an integer square root of the clamped quotient, digit-by-digit, one result bit per cycle, with result = floor(sqrt(x)).
REQ-021 SHALL assert done for exactly one cycle in DONE, with mean_sq, rms_out, sat and err_zero updated on that same cycle.
REQ-022 SHALL assert done exactly SUM_W+OUT_W+2 cycles (66 at defaults) after the edge on which start is sampled.
REQ-023 SHALL, when cnt_in==0, skip DIV and SQRT (IDLE->DONE), drive mean_sq=0, rms_out=0, err_zero=1, sat=0, and pulse done 1 cycle after start.
REQ-024 SHALL clear err_zero on any completed request with cnt_in!=0.
REQ-025 SHALL hold mean_sq, rms_out, sat and err_zero stable between done pulses.
REQ-026 SHALL, if start and done coincide, ignore start; a new start is accepted from the first IDLE cycle.

Reset
REQ-027 SHALL, on rst_n low, asynchronously force state IDLE and set busy=0, done=0, mean_sq=0, rms_out=0, err_zero=0, sat=0, and clear all internal registers.
REQ-028 SHALL, when reset is asserted mid-calculation, abort that calculation with no done pulse; after release, the block SHALL accept start on the first rising edge.

Structure
REQ-029 SHALL take SUM_W/CNT_W/OUT_W defaults, the state encoding and the latency constant (SUM_W+OUT_W+2) from a shared package, rms_pkg.
REQ-030 SHALL place the sequential square root in one sub-module, isqrt_seq, with ports start/x/busy/done/root, the same clock and reset, and OUT_W-cycle latency.
REQ-031 SHALL contain the divider inline in rms_calc and use no vendor divider/sqrt IP and no multipliers.

Verification
REQ-032 SHALL cover: sum_in=504000000, cnt_in=504 -> mean_sq=1000000, rms_out=1000, sat=0, done exactly 66 cycles after start.
REQ-033 SHALL cover: sum_in=3, cnt_in=2 -> mean_sq=1, rms_out=1; and sum_in=0, cnt_in=504 -> mean_sq=0, rms_out=0.
REQ-034 SHALL cover: sum_in=1000, cnt_in=0 -> err_zero=1, mean_sq=0, rms_out=0, done 1 cycle after start; a following valid request clears err_zero.
REQ-035 SHALL cover: sum_in=2^48-1, cnt_in=1 -> sat=1, mean_sq=0xFFFFFFFF, rms_out=65535.
REQ-036 SHALL cover: a second start pulsed 10 cycles after the first -> ignored, exactly one done, results from the first inputs only.
REQ-037 SHALL cover: rst_n low at cycle 30 of a calculation -> no done, all outputs 0; a new start after release -> correct result at cycle 66.

Source files
------------

// File: rtl/rms_pkg.sv
// Shared defaults, FSM encoding and completion-latency helper for the RMS calculator.
package rms_pkg;

  localparam int SUM_W_DEF = 48;
  localparam int CNT_W_DEF = 14;
  localparam int OUT_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIV,
    ST_SQRT,
    ST_DONE
  } rms_state_t;

  // Cycles from the start-sampling edge to the done cycle (inclusive).
  function automatic int rms_latency(input int sum_w, input int out_w);
    return sum_w + out_w + 2;
  endfunction

endpackage

// File: rtl/isqrt_seq.sv
// Sequential digit-by-digit integer square root: root = floor(sqrt(x)), one root bit per cycle.
// The first bit is resolved on the start edge, so done pulses OUT_W-1 edges later; start is ignored while busy.
module isqrt_seq
  import rms_pkg::*;
#(
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic               CLK_50M,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2*OUT_W-1:0] x,
  output logic               busy,
  output logic               done,
  output logic [OUT_W-1:0]   root
);

  localparam int CW = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  logic [2*OUT_W-1:0] r_x;
  logic [OUT_W-1:0]   r_rem;
  logic [OUT_W-1:0]   r_root;
  logic [CW-1:0]      r_cnt;
  logic               r_busy;
  logic               r_done;

  logic               w_load;
  logic               w_step;
  logic [2*OUT_W-1:0] w_x_in;
  logic [OUT_W-1:0]   w_rem_in;
  logic [OUT_W-1:0]   w_root_in;
  logic [OUT_W+1:0]   w_acc;
  logic [OUT_W+1:0]   w_trial;
  logic               w_ge;
  logic [OUT_W-1:0]   w_rem_nx;

  assign w_load    = start && !r_busy;
  assign w_step    = w_load || r_busy;
  assign w_x_in    = w_load ? x : r_x;
  assign w_rem_in  = w_load ? '0 : r_rem;
  assign w_root_in = w_load ? '0 : r_root;

  // Remainder stays below 2^OUT_W until the last step, whose remainder is never used.
  assign w_acc    = {w_rem_in, w_x_in[2*OUT_W-1 -: 2]};
  assign w_trial  = {w_root_in, 2'b01};
  assign w_ge     = (w_acc >= w_trial);
  assign w_rem_nx = w_ge ? (w_acc[OUT_W-1:0] - w_trial[OUT_W-1:0]) : w_acc[OUT_W-1:0];

  always_ff @(posedge CLK_50M or negedge rst_n) begin
    if (!rst_n) begin
      r_x    <= '0;
      r_rem  <= '0;
      r_root <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_step) begin
        r_x    <= {w_x_in[2*OUT_W-3:0], 2'b00};
        r_rem  <= w_rem_nx;
        r_root <= {w_root_in[OUT_W-2:0], w_ge};
      end
      if (w_load) begin
        r_busy <= 1'b1;
        r_cnt  <= CW'(OUT_W - 1);
      end else if (r_busy) begin
        r_cnt <= r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign root = r_root;

endmodule

// File: rtl/rms_calc.sv
// RMS of one window: restoring divide sum/cnt (saturated to 2*OUT_W bits), then sequential isqrt.
// done is high in DONE, SUM_W+OUT_W+2 cycles after start (1 cycle for cnt==0); start ignored unless IDLE.
module rms_calc
  import rms_pkg::*;
#(
  parameter int SUM_W = SUM_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic               CLK_50M,
  input  logic               rst_n,
  input  logic               start,
  input  logic [SUM_W-1:0]   sum_in,
  input  logic [CNT_W-1:0]   cnt_in,
  output logic               busy,
  output logic               done,
  output logic [2*OUT_W-1:0] mean_sq,
  output logic [OUT_W-1:0]   rms_out,
  output logic               err_zero,
  output logic               sat
);

  localparam int LATENCY = rms_latency(SUM_W, OUT_W);
  // Latency minus sqrt run, its launch cycle and DONE; counter is zero-based.
  localparam int DIV_LAST = LATENCY - OUT_W - 3;
  localparam int IW = $clog2(SUM_W + 1);

  rms_state_t         r_state;
  rms_state_t         w_state_nx;
  logic [SUM_W-1:0]   r_dvd;
  logic [CNT_W-1:0]   r_dvs;
  logic [CNT_W-1:0]   r_rem;
  logic [IW-1:0]      r_iter;
  logic               r_sq_go;
  logic [2*OUT_W-1:0] r_mean_sq;
  logic [OUT_W-1:0]   r_rms;
  logic               r_err;
  logic               r_sat;

  logic [CNT_W:0]     w_trial;
  logic               w_ge;
  logic [CNT_W-1:0]   w_rem_nx;
  logic               w_sat;
  logic [2*OUT_W-1:0] w_clamped;
  logic               w_sq_start;
  logic               w_sq_busy;
  logic               w_sq_done;
  logic [OUT_W-1:0]   w_root;

  // Quotient bits shift into r_dvd as dividend bits leave from the top.
  assign w_trial  = {r_rem, r_dvd[SUM_W-1]};
  assign w_ge     = (w_trial >= {1'b0, r_dvs});
  assign w_rem_nx = w_ge ? (w_trial[CNT_W-1:0] - r_dvs) : w_trial[CNT_W-1:0];

  assign w_sat      = |r_dvd[SUM_W-1:2*OUT_W];
  assign w_clamped  = w_sat ? '1 : r_dvd[2*OUT_W-1:0];
  assign w_sq_start = r_sq_go && !w_sq_busy;

  isqrt_seq #(.OUT_W(OUT_W)) u_isqrt (
    .CLK_50M (CLK_50M),
    .rst_n   (rst_n),
    .start   (w_sq_start),
    .x       (w_clamped),
    .busy    (w_sq_busy),
    .done    (w_sq_done),
    .root    (w_root)
  );

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nx = (cnt_in == '0) ? ST_DONE : ST_DIV;
      ST_DIV:  if (r_iter == IW'(DIV_LAST)) w_state_nx = ST_SQRT;
      ST_SQRT: if (w_sq_done) w_state_nx = ST_DONE;
      ST_DONE: w_state_nx = ST_IDLE;
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_50M or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_dvd     <= '0;
      r_dvs     <= '0;
      r_rem     <= '0;
      r_iter    <= '0;
      r_sq_go   <= 1'b0;
      r_mean_sq <= '0;
      r_rms     <= '0;
      r_err     <= 1'b0;
      r_sat     <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_sq_go <= 1'b0;
      case (r_state)
        ST_IDLE: if (start) begin
          r_dvd  <= sum_in;
          r_dvs  <= cnt_in;
          r_rem  <= '0;
          r_iter <= '0;
        end
        ST_DIV: begin
          r_dvd  <= {r_dvd[SUM_W-2:0], w_ge};
          r_rem  <= w_rem_nx;
          r_iter <= r_iter + IW'(1);
          if (r_iter == IW'(DIV_LAST)) r_sq_go <= 1'b1;
        end
        default: ;
      endcase
      if (w_state_nx == ST_DONE && r_state != ST_DONE) begin
        if (r_state == ST_IDLE) begin
          r_mean_sq <= '0;
          r_rms     <= '0;
          r_sat     <= 1'b0;
          r_err     <= 1'b1;
        end else begin
          r_mean_sq <= w_clamped;
          r_rms     <= w_root;
          r_sat     <= w_sat;
          r_err     <= 1'b0;
        end
      end
    end
  end

  assign busy     = (r_state != ST_IDLE);
  assign done     = (r_state == ST_DONE);
  assign mean_sq  = r_mean_sq;
  assign rms_out  = r_rms;
  assign err_zero = r_err;
  assign sat      = r_sat;

endmodule

// File: tb/tb_rms_calc.sv
// Scoreboard bench for rms_calc: stimulus pushes hand-computed results, a negedge monitor checks each done.
module tb_rms_calc;

  logic        CLK_50M = 1'b0;
  logic        rst_n   = 1'b0;
  logic        start   = 1'b0;
  logic [47:0] sum_in  = '0;
  logic [13:0] cnt_in  = '0;
  logic        busy, done, err_zero, sat;
  logic [31:0] mean_sq;
  logic [15:0] rms_out;

  rms_calc dut (
    .CLK_50M  (CLK_50M),
    .rst_n    (rst_n),
    .start    (start),
    .sum_in   (sum_in),
    .cnt_in   (cnt_in),
    .busy     (busy),
    .done     (done),
    .mean_sq  (mean_sq),
    .rms_out  (rms_out),
    .err_zero (err_zero),
    .sat      (sat)
  );

  always #10 CLK_50M = ~CLK_50M;

  typedef struct {
    logic [31:0] m;
    logic [15:0] r;
    logic        s;
    logic        e;
    int          lat;
    int          t0;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  logic prev_done = 1'b0;

  always @(posedge CLK_50M) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0d, required %0d", name, act, req);
    end
  endtask

  // Monitor: every done cycle consumes one scoreboard entry.
  always @(negedge CLK_50M) begin : mon
    exp_t e;
    if (rst_n && done) begin
      check("done_one_cycle", 64'(prev_done), 64'd0);
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: actual done=1 with nothing outstanding, required done=0");
      end else begin
        e = sb.pop_front();
        check("mean_sq", 64'(mean_sq), 64'(e.m));
        check("rms_out", 64'(rms_out), 64'(e.r));
        check("sat", 64'(sat), 64'(e.s));
        check("err_zero", 64'(err_zero), 64'(e.e));
        check("latency", 64'(cyc - e.t0 + 1), 64'(e.lat));
      end
    end
    prev_done = done;
  end

  task automatic req(input logic [47:0] s, input logic [13:0] c, input logic [31:0] m,
                     input logic [15:0] r, input logic se, input logic ee, input int lat,
                     input bit push);
    exp_t e;
    @(posedge CLK_50M); #1;
    start = 1'b1; sum_in = s; cnt_in = c;
    if (push) begin
      e.m = m; e.r = r; e.s = se; e.e = ee; e.lat = lat; e.t0 = cyc + 1;
      sb.push_back(e);
    end
    @(posedge CLK_50M); #1;
    start = 1'b0; sum_in = 48'hA5A5_5A5A_F00F; cnt_in = 14'd3;
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(posedge CLK_50M);
      k++;
    end
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL done_timeout: actual no done within %0d cycles, required done", budget);
      sb.delete();
    end
  endtask

  task automatic hold_check(input logic [31:0] m, input logic [15:0] r, input logic se, input logic ee);
    repeat (3) @(posedge CLK_50M);
    #1;
    check("hold_busy", 64'(busy), 64'd0);
    check("hold_mean_sq", 64'(mean_sq), 64'(m));
    check("hold_rms_out", 64'(rms_out), 64'(r));
    check("hold_sat", 64'(sat), 64'(se));
    check("hold_err_zero", 64'(err_zero), 64'(ee));
  endtask

  task automatic zero_check(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_mean_sq"}, 64'(mean_sq), 64'd0);
    check({tag, "_rms_out"}, 64'(rms_out), 64'd0);
    check({tag, "_err_zero"}, 64'(err_zero), 64'd0);
    check({tag, "_sat"}, 64'(sat), 64'd0);
  endtask

  initial begin
    repeat (3) @(posedge CLK_50M);
    #1;
    zero_check("reset");
    rst_n = 1'b1;

    req(48'd504000000, 14'd504, 32'd1000000, 16'd1000, 1'b0, 1'b0, 66, 1'b1);
    repeat (5) @(posedge CLK_50M);
    #1;
    check("busy_mid_calc", 64'(busy), 64'd1);
    drain(100);
    hold_check(32'd1000000, 16'd1000, 1'b0, 1'b0);

    req(48'd3, 14'd2, 32'd1, 16'd1, 1'b0, 1'b0, 66, 1'b1);
    drain(100);
    req(48'd0, 14'd504, 32'd0, 16'd0, 1'b0, 1'b0, 66, 1'b1);
    drain(100);

    req(48'd1000, 14'd0, 32'd0, 16'd0, 1'b0, 1'b1, 1, 1'b1);
    drain(10);
    hold_check(32'd0, 16'd0, 1'b0, 1'b1);
    req(48'd99, 14'd1, 32'd99, 16'd9, 1'b0, 1'b0, 66, 1'b1);
    drain(100);

    req(48'hFFFF_FFFF_FFFF, 14'd1, 32'hFFFF_FFFF, 16'd65535, 1'b1, 1'b0, 66, 1'b1);
    drain(100);
    hold_check(32'hFFFF_FFFF, 16'd65535, 1'b1, 1'b0);
    req(48'd100, 14'd7, 32'd14, 16'd3, 1'b0, 1'b0, 66, 1'b1);
    drain(100);

    // Second start ten cycles in must be dropped.
    req(48'd5000, 14'd2, 32'd2500, 16'd50, 1'b0, 1'b0, 66, 1'b1);
    repeat (8) @(posedge CLK_50M);
    req(48'd1000000, 14'd1, 32'd0, 16'd0, 1'b0, 1'b0, 0, 1'b0);
    drain(100);
    repeat (80) @(posedge CLK_50M);
    hold_check(32'd2500, 16'd50, 1'b0, 1'b0);

    // Reset at cycle 30 aborts; a start right at release must be accepted.
    req(48'd504000000, 14'd504, 32'd0, 16'd0, 1'b0, 1'b0, 0, 1'b0);
    repeat (28) @(posedge CLK_50M);
    #1;
    rst_n = 1'b0;
    #1;
    zero_check("abort");
    repeat (3) @(posedge CLK_50M);
    @(negedge CLK_50M);
    rst_n = 1'b1;
    start = 1'b1; sum_in = 48'd8100; cnt_in = 14'd100;
    begin
      exp_t e;
      e.m = 32'd81; e.r = 16'd9; e.s = 1'b0; e.e = 1'b0; e.lat = 66; e.t0 = cyc + 1;
      sb.push_back(e);
    end
    @(posedge CLK_50M); #1;
    start = 1'b0;
    drain(100);
    hold_check(32'd81, 16'd9, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
